// File: rtl/mem_arb_pkg.sv
// Shared constants for the memory port arbiter: FSM encoding, requester IDs
// and the round-robin pick helper.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic REQ_IF  = 1'b0;
  localparam logic REQ_MEM = 1'b1;

  // Winner for a new arbitration. On a tie, the requester that was not
  // served last wins. Otherwise the only active requester wins.
  function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return ~last;
    return r1;
  endfunction

endpackage

// File: rtl/mux2_bus.sv
// W-bit 2:1 word mux. Steered by the registered grant so that the memory-side
// buses never see a combinational path from the request inputs.
module mux2_bus #(
  parameter int W = 1
) (
  input  logic         sel,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  output logic [W-1:0] out
);

  // select in1 when sel is high, otherwise in0
  always_comb out = sel ? in1 : in0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (requester 0) and
// data access (requester 1). Fixed-latency access sequencer with round-robin
// arbitration on contention; the losing requester stalls because its ack is
// withheld.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | waiting for a request; arbitrates and latches sel
//   ST_ACCESS | memory enabled for MEM_LAT cycles; rdata captured on last
//   ST_RESP   | one-cycle ack to the granted requester
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          we0,
  input  logic          we1,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] rdata,
  output logic          ack0,
  output logic          ack1,
  output logic          sel,
  output logic          busy
);

  // counter holds MEM_LAT-1 down to 0, so it never needs more than clog2(MEM_LAT) bits
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          last_grant;
  logic          sel_we;

  mux2_bus #(.W(AW)) u_mux_addr (
    .sel (sel),
    .in0 (addr0),
    .in1 (addr1),
    .out (mem_addr)
  );

  mux2_bus #(.W(DW)) u_mux_wdata (
    .sel (sel),
    .in0 (wdata0),
    .in1 (wdata1),
    .out (mem_wdata)
  );

  mux2_bus #(.W(1)) u_mux_we (
    .sel (sel),
    .in0 (we0),
    .in1 (we1),
    .out (sel_we)
  );

  // sequencer: arbitrate in idle, count out the access latency, then respond
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      sel        <= REQ_IF;
      last_grant <= REQ_MEM;
      cnt        <= '0;
      rdata      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req0 || req1) begin
            sel   <= rr_pick(req0, req1, last_grant);
            cnt   <= CNT_LOAD;
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            if (!sel_we) rdata <= mem_rdata;
            last_grant <= sel;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // outputs decoded from registered state and grant only
  always_comb begin
    mem_en = (state == ST_ACCESS);
    mem_we = sel_we && mem_en;
    ack0   = (state == ST_RESP) && (sel == REQ_IF);
    ack1   = (state == ST_RESP) && (sel == REQ_MEM);
    busy   = (state != ST_IDLE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized two-requester
// traffic, checked every cycle against a transaction-timing reference model.
module tb_mem_port_arbiter;

  localparam int L = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [31:0] mem_rdata, mem_addr, mem_wdata, rdata;
  logic        mem_en, mem_we, ack0, ack1, sel, busy;

  // second instance with single-cycle memory latency
  logic        req0_l1, req1_l1, we0_l1, we1_l1;
  logic [31:0] addr0_l1, addr1_l1, wdata0_l1, wdata1_l1;
  logic [31:0] mem_rdata_l1, mem_addr_l1, mem_wdata_l1, rdata_l1;
  logic        mem_en_l1, mem_we_l1, ack0_l1, ack1_l1, sel_l1, busy_l1;

  logic [31:0] mem    [0:255];
  logic [31:0] shadow [0:255];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(L)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1),
    .mem_rdata(mem_rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .rdata(rdata),
    .ack0(ack0), .ack1(ack1), .sel(sel), .busy(busy)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .req0(req0_l1), .req1(req1_l1), .addr0(addr0_l1), .addr1(addr1_l1),
    .wdata0(wdata0_l1), .wdata1(wdata1_l1), .we0(we0_l1), .we1(we1_l1),
    .mem_rdata(mem_rdata_l1), .mem_en(mem_en_l1), .mem_we(mem_we_l1),
    .mem_addr(mem_addr_l1), .mem_wdata(mem_wdata_l1), .rdata(rdata_l1),
    .ack0(ack0_l1), .ack1(ack1_l1), .sel(sel_l1), .busy(busy_l1)
  );

  // memory device: combinational read, synchronous write
  assign mem_rdata    = mem[mem_addr[7:0]];
  assign mem_rdata_l1 = mem[mem_addr_l1[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;

  // reference model: a transaction granted at edge g occupies periods
  // g..g+L-1 (access) and g+L (ack); arbitration reopens at edge g+L+2
  bit          m_act;
  int          m_g, m_free;
  logic        m_last, m_sel, m_we;
  logic [31:0] m_addr, m_wdata, m_rdata, m_exp_rd;
  logic        exp_ack0, exp_ack1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    logic inacc, inresp;
    if (reset) begin
      m_act = 0; m_free = cyc + 1; m_last = 1'b1; m_sel = 1'b0; m_rdata = '0;
    end else begin
      if (m_act && cyc == m_g + L && !m_we) m_rdata = m_exp_rd;
      if (cyc >= m_free && (req0 || req1)) begin
        m_sel   = (req0 && req1) ? ~m_last : req1;
        m_last  = m_sel;
        m_act   = 1;
        m_g     = cyc;
        m_free  = cyc + L + 2;
        m_we    = m_sel ? we1 : we0;
        m_addr  = m_sel ? addr1 : addr0;
        m_wdata = m_sel ? wdata1 : wdata0;
        if (m_we) shadow[m_addr[7:0]] = m_wdata;
        else      m_exp_rd = shadow[m_addr[7:0]];
      end
    end
    @(posedge clk);
    @(negedge clk);
    inacc    = m_act && cyc >= m_g && cyc < m_g + L;
    inresp   = m_act && cyc == m_g + L;
    exp_ack0 = inresp && !m_sel;
    exp_ack1 = inresp && m_sel;
    chk("mem_en", mem_en, inacc);
    chk("mem_we", mem_we, inacc && m_we);
    chk("ack0", ack0, exp_ack0);
    chk("ack1", ack1, exp_ack1);
    chk("busy", busy, inacc || inresp);
    chk("sel", sel, m_sel);
    chk("rdata", rdata, m_rdata);
    if (inacc) begin
      chk("mem_addr", mem_addr, m_addr);
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end else begin
      chk("addr_mux", mem_addr, m_sel ? addr1 : addr0);
    end
    cyc++;
  endtask

  task automatic new_req(input bit n);
    if (!n) begin
      req0 = 1'b1; addr0 = 32'($urandom_range(0, 255));
      we0 = 1'($urandom % 2); wdata0 = $urandom;
    end else begin
      req1 = 1'b1; addr1 = 32'($urandom_range(0, 255));
      we1 = 1'($urandom % 2); wdata1 = $urandom;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int ack_at, en_cnt, a1_cnt, n;
    int t_ack [0:3];
    logic [31:0] who [0:3];
    logic [31:0] saved;

    for (int i = 0; i < 256; i++) begin
      mem[i]    = 32'(i) * 32'h0101_0101 ^ 32'h5A5A_0000;
      shadow[i] = 32'(i) * 32'h0101_0101 ^ 32'h5A5A_0000;
    end
    mem[8'h40] = 32'hDEADBEEF; shadow[8'h40] = 32'hDEADBEEF;
    mem[8'h44] = 32'hCAFEF00D; shadow[8'h44] = 32'hCAFEF00D;

    reset = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 32'h0000_0040; addr1 = 32'h0000_0080; wdata0 = '0; wdata1 = '0;
    req0_l1 = 0; req1_l1 = 0; we0_l1 = 0; we1_l1 = 0;
    addr0_l1 = 32'h44; addr1_l1 = 32'h0; wdata0_l1 = '0; wdata1_l1 = '0;
    m_act = 0; m_g = 0; m_free = 0; m_last = 1'b1; m_sel = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_exp_rd = '0;
    exp_ack0 = 0; exp_ack1 = 0;

    // 1: reset state
    for (int i = 0; i < 3; i++) step();
    chk("t1_sel", sel, 0);
    chk("t1_busy", busy, 0);
    chk("t1_rdata", rdata, 0);
    chk("t1_addr", mem_addr, 32'h40);
    chk("t1_l1_busy", busy_l1, 0);
    chk("t1_l1_rdata", rdata_l1, 0);
    reset = 1'b0;

    // 2: single read from requester 0
    req0 = 1; addr0 = 32'h40; we0 = 0;
    ack_at = 0; en_cnt = 0; a1_cnt = 0;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (mem_en) en_cnt++;
      if (ack1) a1_cnt++;
      if (ack0) begin ack_at = k; req0 = 0; end
    end
    chk("t2_en_cnt", en_cnt, 2);
    chk("t2_ack_at", ack_at, 3);
    chk("t2_ack1", a1_cnt, 0);
    chk("t2_rdata", rdata, 32'hDEADBEEF);

    // 3: contention after reset alternates 0,1,0,1 with acks 4 cycles apart
    reset = 1; step(); reset = 0;
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 32'h10; addr1 = 32'h20;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (n < 4 && (ack0 || ack1)) begin
        who[n] = {31'd0, ack1}; t_ack[n] = k; n++;
        if (n == 4) begin req0 = 0; req1 = 0; end
      end
    end
    chk("t3_n", n, 4);
    for (int i = 0; i < 4; i++) chk("t3_who", (i < n) ? who[i] : 32'hx, 32'(i % 2));
    for (int i = 0; i < 3; i++) chk("t3_gap", (i + 1 < n) ? 32'(t_ack[i+1] - t_ack[i]) : 32'hx, 4);

    // 4: write from requester 1 leaves rdata alone
    saved = rdata;
    req1 = 1; addr1 = 32'h80; wdata1 = 32'h12345678; we1 = 1;
    ack_at = 0; en_cnt = 0;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (mem_we) begin en_cnt++; chk("t4_addr", mem_addr, 32'h80); end
      if (ack1) begin ack_at = k; req1 = 0; we1 = 0; end
    end
    chk("t4_we_cnt", en_cnt, 2);
    chk("t4_ack_at", ack_at, 3);
    chk("t4_rdata", rdata, saved);
    chk("t4_memval", mem[8'h80], 32'h12345678);

    // 5: reset during access aborts; held request then served
    req0 = 1; addr0 = 32'h10; we0 = 0;
    step();
    chk("t5_en_pre", mem_en, 1);
    reset = 1; step();
    chk("t5_en", mem_en, 0);
    chk("t5_ack", {ack0, ack1}, 0);
    chk("t5_busy", busy, 0);
    reset = 0;
    ack_at = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (ack0) begin ack_at = k; req0 = 0; end
    end
    chk("t5_ack_at", ack_at, L + 1);

    // 6: MEM_LAT=1 instance single read
    req0_l1 = 1;
    step();
    chk("t6_en1", mem_en_l1, 1);
    chk("t6_ack_early", ack0_l1, 0);
    step();
    chk("t6_en2", mem_en_l1, 0);
    chk("t6_ack", ack0_l1, 1);
    chk("t6_rdata", rdata_l1, 32'hCAFEF00D);
    req0_l1 = 0;
    step();
    chk("t6_idle", {ack0_l1, ack1_l1, busy_l1}, 0);

    // randomized traffic
    reset = 1; step(); reset = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (exp_ack0) begin if ($urandom % 2) new_req(0); else req0 = 0; end
      else if (!req0 && ($urandom % 4) == 0) new_req(0);
      if (exp_ack1) begin if ($urandom % 2) new_req(1); else req1 = 0; end
      else if (!req1 && ($urandom % 4) == 0) new_req(1);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      if (exp_ack0) req0 = 0;
      if (exp_ack1) req1 = 0;
    end
    chk("drain_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
